mci_axi_main_req: RTL and testbench

Single-outstanding AXI4 manager for the MCI. Converts a simplex request/response port (one read or write at a time) into single-beat AXI4 transactions on a flattened manager port. It is the initiating counterpart of the MCI AXI subordinate path: MCI-internal agents use it to reach SoC targets over AXI.

---
 rtl/mci_pkg.sv | 26 ++
 rtl/mci_axi_main_req_if.sv | 88 ++++++++
 rtl/mci_axi_main_req.sv | 152 +++++++++++++++
 tb/tb_mci_axi_main_req.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mci_pkg.sv
// Shared MCI definitions: AXI manager FSM states, AXI response/burst encodings, size helper.
// Pure declarations; no timing or backpressure behaviour of its own.
// Imported by the AXI manager request block and its interface users.
package mci_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP
   } mci_axi_main_state_e;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

   // AxSIZE encoding for a full-width beat of a dw-bit bus
   function automatic logic [2:0] axi_size(input int unsigned dw);
      return 3'($clog2(dw / 8));
   endfunction

endpackage

// File: rtl/mci_axi_main_req_if.sv
// Bundle for the MCI simplex request/response port plus the flattened AXI4 manager port.
// No latency; master = the AXI manager block, slave = requester plus AXI subordinate side.
// Flow control is the valid/ready of each channel; resp_valid is a pulse without backpressure.
interface mci_axi_main_req_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int IW = 8,
   parameter int UW = 32
);
   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   req_wdata;
   logic [DW/8-1:0] req_wstrb;
   logic [IW-1:0]   req_id;
   logic [UW-1:0]   req_user;
   logic            resp_valid;
   logic [DW-1:0]   resp_rdata;
   logic            resp_error;

   logic            m_awvalid;
   logic            m_awready;
   logic [AW-1:0]   m_awaddr;
   logic [IW-1:0]   m_awid;
   logic [UW-1:0]   m_awuser;
   logic [7:0]      m_awlen;
   logic [2:0]      m_awsize;
   logic [1:0]      m_awburst;

   logic            m_wvalid;
   logic            m_wready;
   logic [DW-1:0]   m_wdata;
   logic [DW/8-1:0] m_wstrb;
   logic            m_wlast;

   logic            m_bvalid;
   logic            m_bready;
   logic [1:0]      m_bresp;
   logic [IW-1:0]   m_bid;

   logic            m_arvalid;
   logic            m_arready;
   logic [AW-1:0]   m_araddr;
   logic [IW-1:0]   m_arid;
   logic [UW-1:0]   m_aruser;
   logic [7:0]      m_arlen;
   logic [2:0]      m_arsize;
   logic [1:0]      m_arburst;

   logic            m_rvalid;
   logic            m_rready;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp;
   logic [IW-1:0]   m_rid;
   logic            m_rlast;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, req_id, req_user,
      output req_ready, resp_valid, resp_rdata, resp_error,
      output m_awvalid, m_awaddr, m_awid, m_awuser, m_awlen, m_awsize, m_awburst,
      input  m_awready,
      output m_wvalid, m_wdata, m_wstrb, m_wlast,
      input  m_wready,
      input  m_bvalid, m_bresp, m_bid,
      output m_bready,
      output m_arvalid, m_araddr, m_arid, m_aruser, m_arlen, m_arsize, m_arburst,
      input  m_arready,
      input  m_rvalid, m_rdata, m_rresp, m_rid, m_rlast,
      output m_rready
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, req_id, req_user,
      input  req_ready, resp_valid, resp_rdata, resp_error,
      input  m_awvalid, m_awaddr, m_awid, m_awuser, m_awlen, m_awsize, m_awburst,
      output m_awready,
      input  m_wvalid, m_wdata, m_wstrb, m_wlast,
      output m_wready,
      output m_bvalid, m_bresp, m_bid,
      input  m_bready,
      input  m_arvalid, m_araddr, m_arid, m_aruser, m_arlen, m_arsize, m_arburst,
      output m_arready,
      output m_rvalid, m_rdata, m_rresp, m_rid, m_rlast,
      input  m_rready
   );

endinterface

// File: rtl/mci_axi_main_req.sv
// Single-outstanding AXI4 manager: one simplex request becomes one single-beat AXI read or write; MCI_AXI_MAIN_ID_CHECK_EN adds B/R ID checking.
// Latency with a zero-wait subordinate: accept c0, AW/W or AR c1, B or R c2, resp_valid c3 (next accept c3).
// req_ready only in IDLE so later requests wait; AXI valids hold until handshake; resp_valid is an unbackpressured pulse.
module mci_axi_main_req
   import mci_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int IW = 8,
   parameter int UW = 32
) (
   input logic                clk,
   input logic                rst,
   mci_axi_main_req_if.master bus
);

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [DW-1:0]   wdata;
      logic [DW/8-1:0] wstrb;
      logic [IW-1:0]   id;
      logic [UW-1:0]   user;
   } req_t;

   mci_axi_main_state_e state_q, state_d;
   req_t                req_q;
   logic                aw_done_q, w_done_q;
   logic                resp_valid_q, resp_error_q;
   logic [DW-1:0]       resp_rdata_q;

   logic req_ready, awvalid, wvalid, bready, arvalid, rready;
   logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic b_id_err, r_id_err;

   assign accept = bus.req_valid & req_ready;
   assign aw_hs  = awvalid & bus.m_awready;
   assign w_hs   = wvalid & bus.m_wready;
   assign b_hs   = bready & bus.m_bvalid;
   assign ar_hs  = arvalid & bus.m_arready;
   assign r_hs   = rready & bus.m_rvalid;

`ifdef MCI_AXI_MAIN_ID_CHECK_EN
   assign b_id_err = (bus.m_bid != req_q.id);
   assign r_id_err = (bus.m_rid != req_q.id);
`else
   logic unused_ids;
   assign b_id_err   = 1'b0;
   assign r_id_err   = 1'b0;
   assign unused_ids = ^{bus.m_bid, bus.m_rid};
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = bus.req_write ? WR_REQ : RD_REQ;
         // AW and W may complete in either order or together
         WR_REQ:  if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = WR_RESP;
         WR_RESP: if (b_hs) state_d = IDLE;
         RD_REQ:  if (ar_hs) state_d = RD_RESP;
         RD_RESP: if (r_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE:    req_ready = 1'b1;
            WR_REQ:  begin
               awvalid = ~aw_done_q;
               wvalid  = ~w_done_q;
            end
            WR_RESP: bready  = 1'b1;
            RD_REQ:  arvalid = 1'b1;
            RD_RESP: rready  = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q        <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         if (accept) begin
            req_q     <= '{addr:  bus.req_addr,  wdata: bus.req_wdata,
                           wstrb: bus.req_wstrb, id:    bus.req_id,
                           user:  bus.req_user};
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end
         if (aw_hs) aw_done_q <= 1'b1;
         if (w_hs)  w_done_q  <= 1'b1;
         resp_valid_q <= b_hs | r_hs;
         if (b_hs) begin
            resp_rdata_q <= '0;
            resp_error_q <= (bus.m_bresp != AXI_RESP_OKAY) | b_id_err;
         end
         if (r_hs) begin
            resp_rdata_q <= bus.m_rdata;
            resp_error_q <= (bus.m_rresp != AXI_RESP_OKAY) | ~bus.m_rlast | r_id_err;
         end
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_error = resp_error_q;

   assign bus.m_awvalid  = awvalid;
   assign bus.m_awaddr   = req_q.addr;
   assign bus.m_awid     = req_q.id;
   assign bus.m_awuser   = req_q.user;
   assign bus.m_awlen    = 8'd0;
   assign bus.m_awsize   = axi_size(DW);
   assign bus.m_awburst  = AXI_BURST_INCR;

   assign bus.m_wvalid   = wvalid;
   assign bus.m_wdata    = req_q.wdata;
   assign bus.m_wstrb    = req_q.wstrb;
   assign bus.m_wlast    = 1'b1;

   assign bus.m_bready   = bready;

   assign bus.m_arvalid  = arvalid;
   assign bus.m_araddr   = req_q.addr;
   assign bus.m_arid     = req_q.id;
   assign bus.m_aruser   = req_q.user;
   assign bus.m_arlen    = 8'd0;
   assign bus.m_arsize   = axi_size(DW);
   assign bus.m_arburst  = AXI_BURST_INCR;

   assign bus.m_rready   = rready;

endmodule

// File: tb/tb_mci_axi_main_req.sv
// Directed bench for mci_axi_main_req: writes, reads, staggered AW/W, back-to-back, reset abort, ID check.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mci_axi_main_req;
   import mci_pkg::*;

`ifdef MCI_AXI_MAIN_ID_CHECK_EN
   localparam logic EXP_ID_ERR = 1'b1;
`else
   localparam logic EXP_ID_ERR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   resp_cnt = 0;
   int   b_cnt = 0;
   int   outst = 0;
   int   max_outst = 0;

   always #5 clk = ~clk;

   mci_axi_main_req_if #(.AW(32), .DW(32), .IW(8), .UW(32)) bus ();

   mci_axi_main_req #(.AW(32), .DW(32), .IW(8), .UW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(posedge clk) begin
      if (!rst) begin
         if (bus.resp_valid === 1'b1) resp_cnt++;
         if (bus.m_bvalid === 1'b1 && bus.m_bready === 1'b1) b_cnt++;
         outst = outst + ((bus.req_valid === 1'b1 && bus.req_ready === 1'b1) ? 1 : 0)
                       - ((bus.resp_valid === 1'b1) ? 1 : 0);
         if (outst > max_outst) max_outst = outst;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic rd_txn(input string tag, input logic [31:0] addr, input logic [7:0] id,
                         input logic [31:0] rdata, input logic [1:0] rresp,
                         input logic [7:0] rid, input logic rlast, input logic exp_err);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = addr;
      bus.req_id    = id;
      bus.m_arready = 1'b1;
      chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
      cyc();
      bus.req_valid = 1'b0;
      chk({tag, "_arvalid"}, 64'(bus.m_arvalid), 64'd1);
      chk({tag, "_araddr"}, 64'(bus.m_araddr), 64'(addr));
      chk({tag, "_arid"}, 64'(bus.m_arid), 64'(id));
      chk({tag, "_arfix"}, 64'({bus.m_arlen, bus.m_arsize, bus.m_arburst}), 64'({8'd0, 3'd2, 2'b01}));
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = rdata;
      bus.m_rresp  = rresp;
      bus.m_rid    = rid;
      bus.m_rlast  = rlast;
      cyc();
      chk({tag, "_rready"}, 64'(bus.m_rready), 64'd1);
      chk({tag, "_arvalid_drop"}, 64'(bus.m_arvalid), 64'd0);
      cyc();
      bus.m_rvalid = 1'b0;
      chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd1);
      chk({tag, "_resp_rdata"}, 64'(bus.resp_rdata), 64'(rdata));
      chk({tag, "_resp_error"}, 64'(bus.resp_error), 64'(exp_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wstrb = '0;
      bus.req_id    = '0;
      bus.req_user  = '0;
      bus.m_awready = 1'b0;
      bus.m_wready  = 1'b0;
      bus.m_bvalid  = 1'b0;
      bus.m_bresp   = AXI_RESP_OKAY;
      bus.m_bid     = '0;
      bus.m_arready = 1'b0;
      bus.m_rvalid  = 1'b0;
      bus.m_rdata   = '0;
      bus.m_rresp   = AXI_RESP_OKAY;
      bus.m_rid     = '0;
      bus.m_rlast   = 1'b0;

      // reset state
      cyc();
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_valids", 64'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}), 64'd0);
      chk("rst_readies", 64'({bus.m_bready, bus.m_rready}), 64'd0);
      chk("rst_resp", 64'({bus.resp_valid, bus.resp_error}), 64'd0);
      chk("rst_awaddr", 64'(bus.m_awaddr), 64'd0);
      rst = 1'b0;
      cyc();
      chk("idle_req_ready", 64'(bus.req_ready), 64'd1);

      // zero-wait write
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h1000;
      bus.req_wdata = 32'hDEADBEEF;
      bus.req_wstrb = 4'hF;
      bus.req_id    = 8'h01;
      bus.req_user  = 32'h55;
      bus.m_awready = 1'b1;
      bus.m_wready  = 1'b1;
      cyc();
      bus.req_valid = 1'b0;
      chk("wr1_valids", 64'({bus.m_awvalid, bus.m_wvalid}), 64'b11);
      chk("wr1_awaddr", 64'(bus.m_awaddr), 64'h1000);
      chk("wr1_wdata", 64'(bus.m_wdata), 64'hDEADBEEF);
      chk("wr1_wstrb_wlast", 64'({bus.m_wstrb, bus.m_wlast}), 64'b11111);
      chk("wr1_awfix", 64'({bus.m_awlen, bus.m_awsize, bus.m_awburst}), 64'({8'd0, 3'd2, 2'b01}));
      chk("wr1_awuser", 64'(bus.m_awuser), 64'h55);
      chk("wr1_req_ready", 64'(bus.req_ready), 64'd0);
      chk("wr1_bready_c1", 64'(bus.m_bready), 64'd0);
      bus.m_bvalid = 1'b1;
      bus.m_bresp  = AXI_RESP_OKAY;
      bus.m_bid    = 8'h01;
      cyc();
      chk("wr1_bready_c2", 64'(bus.m_bready), 64'd1);
      chk("wr1_valids_c2", 64'({bus.m_awvalid, bus.m_wvalid}), 64'b00);
      cyc();
      bus.m_bvalid = 1'b0;
      chk("wr1_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("wr1_resp_err_rdata", 64'({bus.resp_error, bus.resp_rdata}), 64'd0);
      chk("wr1_req_ready_c3", 64'(bus.req_ready), 64'd1);
      cyc();
      chk("wr1_resp_pulse", 64'(bus.resp_valid), 64'd0);

      // write with W ready three cycles ahead of AW
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h1004;
      bus.req_wdata = 32'h12345678;
      bus.req_wstrb = 4'h3;
      bus.m_awready = 1'b0;
      bus.m_wready  = 1'b1;
      cyc();
      bus.req_valid = 1'b0;
      chk("wr2_valids_c1", 64'({bus.m_awvalid, bus.m_wvalid}), 64'b11);
      cyc();
      chk("wr2_valids_c2", 64'({bus.m_awvalid, bus.m_wvalid}), 64'b10);
      chk("wr2_awaddr_hold", 64'(bus.m_awaddr), 64'h1004);
      cyc();
      chk("wr2_valids_c3", 64'({bus.m_awvalid, bus.m_wvalid, bus.m_bready}), 64'b100);
      cyc();
      chk("wr2_valids_c4", 64'({bus.m_awvalid, bus.m_wvalid}), 64'b10);
      bus.m_awready = 1'b1;
      bus.m_bvalid  = 1'b1;
      bus.m_bresp   = AXI_RESP_OKAY;
      cyc();
      chk("wr2_bready", 64'({bus.m_awvalid, bus.m_bready}), 64'b01);
      cyc();
      bus.m_bvalid = 1'b0;
      chk("wr2_resp", 64'({bus.resp_valid, bus.resp_error}), 64'b10);
      cyc();
      chk("wr2_b_count", 64'(b_cnt), 64'd2);

      // read with SLVERR
      rd_txn("rd_slverr", 32'h2000, 8'h02, 32'hA5A5A5A5, AXI_RESP_SLVERR, 8'h02, 1'b1, 1'b1);
      cyc();

      // back-to-back requests held on req_valid, zero-wait subordinate
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h3000;
      bus.req_id    = 8'h05;
      bus.m_arready = 1'b1;
      bus.m_rvalid  = 1'b1;
      bus.m_rdata   = 32'h11;
      bus.m_rresp   = AXI_RESP_OKAY;
      bus.m_rid     = 8'h05;
      bus.m_rlast   = 1'b1;
      chk("b2b_accept0", 64'(bus.req_ready), 64'd1);
      cyc();
      chk("b2b_c1", 64'({bus.req_ready, bus.m_arvalid}), 64'b01);
      cyc();
      chk("b2b_c2", 64'({bus.req_ready, bus.m_rready}), 64'b01);
      cyc();
      chk("b2b_c3", 64'({bus.resp_valid, bus.req_ready}), 64'b11);
      chk("b2b_rdata1", 64'(bus.resp_rdata), 64'h11);
      bus.req_addr = 32'h3004;
      bus.m_rdata  = 32'h22;
      cyc();
      bus.req_valid = 1'b0;
      chk("b2b_second_ar", 64'({bus.m_arvalid, bus.resp_valid}), 64'b10);
      chk("b2b_araddr2", 64'(bus.m_araddr), 64'h3004);
      cyc();
      chk("b2b_rready2", 64'(bus.m_rready), 64'd1);
      cyc();
      bus.m_rvalid = 1'b0;
      chk("b2b_resp2", 64'({bus.resp_valid, bus.resp_error}), 64'b10);
      chk("b2b_rdata2", 64'(bus.resp_rdata), 64'h22);
      cyc();
      chk("b2b_max_outstanding", 64'(max_outst), 64'd1);
      chk("resp_count_pre_rst", 64'(resp_cnt), 64'd5);

      // reset while waiting for B
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h4000;
      bus.m_awready = 1'b1;
      bus.m_wready  = 1'b1;
      cyc();
      bus.req_valid = 1'b0;
      cyc();
      chk("rstmid_in_wr_resp", 64'(bus.m_bready), 64'd1);
      rst = 1'b1;
      cyc();
      chk("rstmid_valids", 64'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}), 64'd0);
      chk("rstmid_readies", 64'({bus.m_bready, bus.m_rready, bus.req_ready}), 64'd0);
      chk("rstmid_resp", 64'(bus.resp_valid), 64'd0);
      chk("rstmid_payload", 64'(bus.m_awaddr), 64'd0);
      rst = 1'b0;
      bus.m_bvalid = 1'b1;
      bus.m_bresp  = AXI_RESP_OKAY;
      cyc();
      chk("rstmid_idle", 64'({bus.req_ready, bus.m_bready, bus.resp_valid}), 64'b100);
      cyc();
      bus.m_bvalid = 1'b0;
      chk("rstmid_no_resp", 64'(bus.resp_valid), 64'd0);
      chk("rstmid_b_count", 64'(b_cnt), 64'd2);

      // ID check, missing RLAST, EXOKAY and DECERR
      rd_txn("rd_id", 32'h5000, 8'h03, 32'hCAFE0001, AXI_RESP_OKAY, 8'h04, 1'b1, EXP_ID_ERR);
      cyc();
      rd_txn("rd_nolast", 32'h5004, 8'h06, 32'hCAFE0002, AXI_RESP_OKAY, 8'h06, 1'b0, 1'b1);
      cyc();
      rd_txn("rd_exokay", 32'h5008, 8'h07, 32'hCAFE0003, AXI_RESP_EXOKAY, 8'h07, 1'b1, 1'b1);
      cyc();
      rd_txn("rd_decerr", 32'h500C, 8'h08, 32'hCAFE0004, AXI_RESP_DECERR, 8'h08, 1'b1, 1'b1);
      cyc();
      chk("resp_count_total", 64'(resp_cnt), 64'd9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
